// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for serial_addsub.
// The master drives the request side; the slave (the unit) drives status and result.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b, sub,
    input  busy, done, sum, carry_out, overflow, zero
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit driving a 1-bit full adder cell, LSB first.
// Define SERIAL_SUB_EN to enable subtraction; otherwise sub is ignored and every operation is A+B.
module adder (
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             cflop;
  logic             cmsb;
  logic [CW-1:0]    cnt;

  logic             add_sum;
  logic             add_carry;
  logic             accept;

  logic [WIDTH-1:0] sum_q;
  logic             done_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic             zero_q;

  logic [WIDTH-1:0] load_b;
  logic             load_cin;

  adder bit_adder (add_sum, add_carry, op_a[0], op_b[0], cflop);

  assign accept = (state == IDLE) && bus.start;

`ifdef SERIAL_SUB_EN
  // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
  assign load_b   = bus.sub ? ~bus.b : bus.b;
  assign load_cin = bus.sub;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign load_b     = bus.b;
  assign load_cin   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      cflop  <= 1'b0;
      cmsb   <= 1'b0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        op_a  <= bus.a;
        op_b  <= load_b;
        cflop <= load_cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        op_a   <= op_a >> 1;
        op_b   <= op_b >> 1;
        result <= {add_sum, result[WIDTH-1:1]};
        cflop  <= add_carry;
        cnt    <= cnt + CW'(1);
        // Carry into the MSB, kept so overflow can compare it with the final carry.
        if (cnt == LAST) begin
          cmsb <= cflop;
        end
      end
    end
  end

  // Result and flags are published on the edge leaving DONE and hold until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      if (state == DONE) begin
        sum_q       <= result;
        carry_out_q <= cflop;
        overflow_q  <= cmsb ^ cflop;
        zero_q      <= (result == '0);
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: an 8-bit and a 4-bit instance against an arithmetic model.
// Honours SERIAL_SUB_EN the same way the design does.
module tb_serial_addsub;

  logic clk;
  logic rst;

  serial_addsub_if #(.WIDTH(8)) bus8 ();
  serial_addsub_if #(.WIDTH(4)) bus4 ();

  serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_addsub #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int checks = 0;
  int passes = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input int w, input int ua, input int ub, input bit s,
                                output int esum, output bit eco, output bit eov, output bit ez);
    int m, half, sa, sb, r, sr;
    bit es;
`ifdef SERIAL_SUB_EN
    es = s;
`else
    es = 1'b0;
`endif
    m    = 1 << w;
    half = 1 << (w - 1);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    if (!es) begin
      r   = ua + ub;
      eco = (r >= m);
      sr  = sa + sb;
    end else begin
      r   = ua - ub;
      eco = (ua >= ub);
      sr  = sa - sb;
    end
    esum = ((r % m) + m) % m;
    eov  = (sr >= half) || (sr < -half);
    ez   = (esum == 0);
  endfunction

  task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = av;
    bus8.b     = bv;
    bus8.sub   = sv;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
  endtask

  task automatic wait8(output int n, output int busy_n, output bit ok);
    n      = 0;
    busy_n = 0;
    ok     = 1'b0;
    if (bus8.busy) busy_n++;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus8.done) begin
        ok = 1'b1;
        break;
      end
      if (bus8.busy) busy_n++;
    end
  endtask

  task automatic start4(input logic [3:0] av, input logic [3:0] bv, input logic sv);
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a     = av;
    bus4.b     = bv;
    bus4.sub   = sv;
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
  endtask

  task automatic wait4(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (bus4.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.sub = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero} !== 12'h000)
      $display("[TB] FAIL reset8: got busy=%b done=%b sum=%h co=%b ov=%b z=%b, want all 0",
               bus8.busy, bus8.done, bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero);
    else passes++;
    checks++;
    if ({bus4.busy, bus4.done, bus4.sum, bus4.carry_out, bus4.overflow, bus4.zero} !== 8'h00)
      $display("[TB] FAIL reset4: got busy=%b done=%b sum=%h, want all 0", bus4.busy, bus4.done, bus4.sum);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_add();
    int n, bn;
    bit ok;
    start8(8'h35, 8'h4A, 1'b0);
    wait8(n, bn, ok);
    checks++;
    if (!ok || n != 9) $display("[TB] FAIL latency: got %0d cycles (done=%b), want 9", n, ok);
    else passes++;
    checks++;
    if (bn != 9) $display("[TB] FAIL busy_len: got %0d, want 9", bn);
    else passes++;
    checks++;
    if ({bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero} !== {8'h7F, 3'b000})
      $display("[TB] FAIL add_35_4a: got sum=%h co=%b ov=%b z=%b, want 7f 0 0 0",
               bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (bus8.done !== 1'b0 || bus8.sum !== 8'h7F)
      $display("[TB] FAIL done_pulse: got done=%b sum=%h, want 0 7f", bus8.done, bus8.sum);
    else passes++;
  endtask

  task automatic test_boundaries();
    int n, bn;
    bit ok;
    start8(8'hFF, 8'h01, 1'b0);
    wait8(n, bn, ok);
    checks++;
    if (!ok || {bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero} !== {8'h00, 3'b101})
      $display("[TB] FAIL add_ff_01: got sum=%h co=%b ov=%b z=%b done=%b, want 00 1 0 1",
               bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero, ok);
    else passes++;
    start8(8'h7F, 8'h01, 1'b0);
    wait8(n, bn, ok);
    checks++;
    if (!ok || {bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero} !== {8'h80, 3'b010})
      $display("[TB] FAIL add_7f_01: got sum=%h co=%b ov=%b z=%b done=%b, want 80 0 1 0",
               bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero, ok);
    else passes++;
  endtask

  task automatic test_sub();
    int n, bn;
    bit ok;
    start8(8'h05, 8'h07, 1'b1);
    wait8(n, bn, ok);
    checks++;
`ifdef SERIAL_SUB_EN
    if (!ok || {bus8.sum, bus8.carry_out, bus8.overflow} !== {8'hFE, 2'b00})
      $display("[TB] FAIL sub_05_07: got sum=%h co=%b ov=%b, want fe 0 0", bus8.sum, bus8.carry_out, bus8.overflow);
    else passes++;
    start8(8'h80, 8'h01, 1'b1);
    wait8(n, bn, ok);
    checks++;
    if (!ok || {bus8.sum, bus8.carry_out, bus8.overflow} !== {8'h7F, 2'b11})
      $display("[TB] FAIL sub_80_01: got sum=%h co=%b ov=%b, want 7f 1 1", bus8.sum, bus8.carry_out, bus8.overflow);
    else passes++;
`else
    if (!ok || {bus8.sum, bus8.carry_out, bus8.overflow} !== {8'h0C, 2'b00})
      $display("[TB] FAIL sub_ignored: got sum=%h co=%b ov=%b, want 0c 0 0", bus8.sum, bus8.carry_out, bus8.overflow);
    else passes++;
`endif
  endtask

  task automatic test_start_ignored();
    int n, first_done, pulses;
    start8(8'h10, 8'h20, 1'b0);
    first_done = -1;
    pulses     = 0;
    for (n = 1; n <= 25; n++) begin
      if (n == 4) begin
        bus8.start = 1'b1;
        bus8.a     = 8'hAA;
        bus8.b     = 8'h55;
      end
      @(posedge clk);
      #1;
      if (n == 4) bus8.start = 1'b0;
      if (bus8.done) begin
        pulses++;
        if (first_done < 0) begin
          first_done = n;
          checks++;
          if (bus8.sum !== 8'h30) $display("[TB] FAIL busy_start_sum: got %h, want 30", bus8.sum);
          else passes++;
        end
      end
    end
    checks++;
    if (first_done != 9) $display("[TB] FAIL busy_start_latency: got %0d, want 9", first_done);
    else passes++;
    checks++;
    if (pulses != 1) $display("[TB] FAIL busy_start_pulses: got %0d, want 1", pulses);
    else passes++;
  endtask

  task automatic test_async_reset();
    int n, bn;
    bit ok;
    start8(8'h35, 8'h4A, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero} !== 12'h000)
      $display("[TB] FAIL async_reset: got busy=%b done=%b sum=%h co=%b ov=%b z=%b, want all 0",
               bus8.busy, bus8.done, bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    start8(8'h01, 8'h02, 1'b0);
    wait8(n, bn, ok);
    checks++;
    if (!ok || n != 9 || bus8.sum !== 8'h03)
      $display("[TB] FAIL after_reset: got sum=%h latency=%0d done=%b, want 03 9", bus8.sum, n, ok);
    else passes++;
  endtask

  task automatic test_random();
    int n, esum;
    bit eco, eov, ez, seen;
    logic [7:0] av, bv;
    logic sv;
    for (int k = 0; k < 30; k++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      sv = 1'($urandom);
      model(8, int'(av), int'(bv), sv, esum, eco, eov, ez);
      start8(av, bv, sv);
      seen = 1'b0;
      for (n = 1; n <= 40; n++) begin
        bus8.a   = 8'($urandom);
        bus8.b   = 8'($urandom);
        bus8.sub = 1'($urandom);
        @(posedge clk);
        #1;
        if (bus8.done) begin
          seen = 1'b1;
          break;
        end
      end
      checks++;
      if (!seen || bus8.sum !== 8'(esum) || bus8.carry_out !== eco || bus8.overflow !== eov || bus8.zero !== ez)
        $display("[TB] FAIL random %h%s%h: got sum=%h co=%b ov=%b z=%b done=%b, want %h %b %b %b",
                 av, sv ? "-" : "+", bv, bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero, seen,
                 8'(esum), eco, eov, ez);
      else passes++;
    end
  endtask

  task automatic test_exhaustive4();
    int n, esum, smax;
    bit ok, eco, eov, ez;
`ifdef SERIAL_SUB_EN
    smax = 1;
`else
    smax = 0;
`endif
    for (int s = 0; s <= smax; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          model(4, x, y, 1'(s), esum, eco, eov, ez);
          start4(4'(x), 4'(y), 1'(s));
          wait4(n, ok);
          checks++;
          if (!ok || n != 5) $display("[TB] FAIL w4_latency %0d,%0d,%0d: got %0d done=%b, want 5", x, y, s, n, ok);
          else passes++;
          checks++;
          if (bus4.sum !== 4'(esum)) $display("[TB] FAIL w4_sum %0d,%0d,%0d: got %h, want %h", x, y, s, bus4.sum, 4'(esum));
          else passes++;
          checks++;
          if (bus4.carry_out !== eco) $display("[TB] FAIL w4_carry %0d,%0d,%0d: got %b, want %b", x, y, s, bus4.carry_out, eco);
          else passes++;
          checks++;
          if (bus4.overflow !== eov) $display("[TB] FAIL w4_ovf %0d,%0d,%0d: got %b, want %b", x, y, s, bus4.overflow, eov);
          else passes++;
          checks++;
          if (bus4.zero !== ez) $display("[TB] FAIL w4_zero %0d,%0d,%0d: got %b, want %b", x, y, s, bus4.zero, ez);
          else passes++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_boundaries();
    test_sub();
    test_start_ignored();
    test_async_reset();
    test_random();
    test_exhaustive4();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
